hdmi_char_overlay: RTL and testbench
====================================

Name: hdmi_char_overlay

Overview:
- Pipelined text-overlay stage between the test-pattern generator (video_display) and dvi_transmitter_top in the 1080p HDMI path.
- Takes the generator's timing, active coordinates and RGB888 pixel. Replaces pixels inside a one-row, NUM_CHARS-wide, 8x16-glyph text window with FG_COLOR (and optionally BG_COLOR).
- Text comes from an internal writable character buffer. Glyph rows come from an external synchronous font ROM.
- All streams are delayed by the same fixed 5 cycles, so sync stays aligned with pixels.

Parameters:
- X_BITS, 12, width of x_in.
- Y_BITS, 12, width of y_in.
- X_START, 64, left pixel column of the text window.
- Y_START, 64, top pixel row of the text window.
- NUM_CHARS, 32, buffer depth and window width in characters (max 32).
- FG_COLOR, 24'hFFFFFF, colour of glyph pixels.
- BG_COLOR, 24'h000000, colour of non-glyph pixels inside the window.
- BG_EN, 0, 1 = fill the window background with BG_COLOR; 0 = background is transparent.
- BLINK_FRAMES, 30, number of frames per blink phase.

Ports:
- pix_clk in 1: pixel clock; the only clock.
- rst in 1: synchronous, active-high reset.
- vs_in in 1: input vsync.
- hs_in in 1: input hsync.
- de_in in 1: input data enable.
- x_in in X_BITS: active x coordinate.
- y_in in Y_BITS: active y coordinate.
- pixel_in in 24: input RGB888 pixel.
- char_we in 1: character buffer write strobe.
- char_waddr in 5: character buffer write address.
- char_wdata in 8: ASCII code to write.
- overlay_en in 1: overlay enable.
- blink_en in 1: blink enable.
- font_addr out 11: font ROM address, {code[6:0], glyph_row[3:0]}.
- font_row in 8: font ROM data, returned 1 cycle after font_addr; bit7 is the leftmost pixel.
- vs_out out 1: delayed vsync.
- hs_out out 1: delayed hsync.
- de_out out 1: delayed data enable.
- pixel_out out 24: output pixel.
- init_done out 1: high once the buffer clear has finished.

Behaviour:
- Reset values: every output 0; FSM in CLEAR; clear counter 0; frame counter 0; blink phase 0; pipeline registers 0.
- FSM CLEAR:
  - Writes 0x20 (space) to buffer address 0..NUM_CHARS-1, one address per cycle.
  - char_we is ignored and overlay is forced off (pass-through only).
  - After writing address NUM_CHARS-1, moves to RUN. init_done goes to 1 on the next cycle and stays 1 until rst.
- FSM RUN:
  - char_we=1 with char_waddr<NUM_CHARS writes char_wdata; addresses >= NUM_CHARS are ignored.
  - A read and a write to the same address in the same cycle returns the old data.
- Window hit:
  - hit = de_in && (X_START <= x_in < X_START+8*NUM_CHARS) && (Y_START <= y_in < Y_START+16).
  - dx = x_in - X_START, dy = y_in - Y_START.
  - col = dx[X_BITS-1:3], bit = dx[2:0], glyph_row = dy[3:0].
- Pipeline, with the input sampled at edge 0:
  - E1: register hit, col, bit, glyph_row, and the delayed vs/hs/de/pixel.
  - E2: synchronous buffer read; code <= buf[col].
  - E3: font_addr <= {code[6:0], glyph_row}.
  - E4: external ROM returns font_row; register it.
  - E5: output register.
- Latency: vs_out/hs_out/de_out/pixel_out reflect the input from exactly 5 cycles earlier. Sync and de pass through unmodified.
- Pixel select at E5:
  - If hit_d && overlay_en_eff: glyph bit = font_row[7-bit_d].
    - Glyph bit 1 -> FG_COLOR.
    - Glyph bit 0 -> BG_COLOR if BG_EN, otherwise pixel_in delayed.
  - Otherwise -> pixel_in delayed.
  - overlay_en_eff = overlay_en && state==RUN && !(blink_en && blink_phase).
  - overlay_en and blink_en are sampled at E1 and travel with the pixel.
- Blink:
  - A rising edge of vs_in increments the frame counter.
  - When the counter equals BLINK_FRAMES-1 at a rising edge, the counter resets to 0 and blink_phase toggles.
  - The phase therefore changes only at frame start (no mid-frame tear).
  - The counter runs even when blink_en=0.
- font_addr holds its last value when there is no hit. It is don't-care to the ROM, but must be deterministic.
- Reset mid-frame: all pipeline contents are discarded (outputs 0 on the next cycle), then CLEAR restarts. No X propagates.

Test Plan:
- Reset release with NUM_CHARS=32 -> init_done rises 33 cycles after rst falls. Reading any address returns 0x20. A write during CLEAR to addr 0 has no effect.
- Write 'A' (0x41) to addr 0; drive x=64, y=64, de=1, pixel_in=24'h123456 with a ROM model where row0 of 0x41 = 8'h80 -> font_addr=11'h410 at E3; pixel_out=24'hFFFFFF exactly 5 cycles after input. At x=65, pixel_out=24'h123456 (BG_EN=0).
- Window boundaries: x=63 and x=64+256=320, and y=63 and y=80, at full glyph -> pixel passes through unchanged. x=319, y=79 -> uses col 31, glyph_row 15.
- Send vs/hs/de toggle patterns with overlay_en=0 -> outputs equal the inputs delayed by 5 cycles, bit-exact.
- blink_en=1, BLINK_FRAMES=2, full glyph -> text visible in frames 0-1, hidden in frames 2-3, visible again in frame 4. Phase changes only at vs rising edges.
- Assert rst mid-line while a hit is in flight -> next cycle all outputs are 0, init_done=0, CLEAR reruns, and pass-through resumes.

Source files
------------

// File: rtl/hdmi_char_overlay.sv
// hdmi_char_overlay: 5-stage text overlay on a video stream using a writable
// character buffer and an external synchronous 8x16 font ROM.
module hdmi_char_overlay #(
    parameter int          X_BITS       = 12,
    parameter int          Y_BITS       = 12,
    parameter int          X_START      = 64,
    parameter int          Y_START      = 64,
    parameter int          NUM_CHARS    = 32,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int          BG_EN        = 0,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic [X_BITS-1:0] x_in,
    input  logic [Y_BITS-1:0] y_in,
    input  logic [23:0]       pixel_in,
    input  logic              char_we,
    input  logic [4:0]        char_waddr,
    input  logic [7:0]        char_wdata,
    input  logic              overlay_en,
    input  logic              blink_en,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_row,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [23:0]       pixel_out,
    output logic              init_done
);
    localparam logic [X_BITS-1:0] X_LO = X_BITS'(X_START);
    localparam logic [X_BITS-1:0] X_HI = X_BITS'(X_START + 8 * NUM_CHARS);
    localparam logic [Y_BITS-1:0] Y_LO = Y_BITS'(Y_START);
    localparam logic [Y_BITS-1:0] Y_HI = Y_BITS'(Y_START + 16);
    localparam int FB = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nx;

    logic [4:0]    clr_cnt;
    logic [6:0]    mem [0:31];
    logic          we;
    logic [4:0]    wa;
    logic [6:0]    wd;
    logic          hit, glyph;
    logic [7:0]    dx;
    logic [3:0]    dy;
    logic [23:0]   pix_sel;
    logic          vs_q, blink_phase;
    logic [FB-1:0] frame_cnt;

    logic          s1_hit, s2_hit, s3_hit, s4_hit;
    logic          s1_ov, s2_ov, s3_ov, s4_ov;
    logic [4:0]    s1_col;
    logic [2:0]    s1_bit, s2_bit, s3_bit, s4_bit;
    logic [3:0]    s1_row, s2_row;
    logic [2:0]    s1_sync, s2_sync, s3_sync, s4_sync;
    logic [23:0]   s1_pix, s2_pix, s3_pix, s4_pix;
    logic [6:0]    code;

    assign hit = de_in && x_in >= X_LO && x_in < X_HI && y_in >= Y_LO && y_in < Y_HI;
    assign dx = 8'(x_in - X_LO);
    assign dy = 4'(y_in - Y_LO);
    assign glyph = font_row[3'd7 - s4_bit];
    assign pix_sel = (s4_hit && s4_ov) ? (glyph ? FG_COLOR : (BG_EN != 0 ? BG_COLOR : s4_pix)) : s4_pix;

    always_comb begin
        state_nx = (state == CLEAR && clr_cnt == 5'(NUM_CHARS - 1)) ? RUN : state;
        we = !rst && (state == CLEAR || (char_we && {1'b0, char_waddr} < 6'(NUM_CHARS)));
        wa = state == CLEAR ? clr_cnt : char_waddr;
        wd = state == CLEAR ? 7'h20 : char_wdata[6:0];
    end

    always_ff @(posedge pix_clk)
        if (we) mem[wa] <= wd;

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state <= CLEAR;
            clr_cnt <= '0;
            init_done <= 1'b0;
            vs_q <= 1'b0;
            frame_cnt <= '0;
            blink_phase <= 1'b0;
            {s1_hit, s1_ov, s1_col, s1_bit, s1_row, s1_sync, s1_pix} <= '0;
            {s2_hit, s2_ov, s2_bit, s2_row, s2_sync, s2_pix, code} <= '0;
            {s3_hit, s3_ov, s3_bit, s3_sync, s3_pix, font_addr} <= '0;
            {s4_hit, s4_ov, s4_bit, s4_sync, s4_pix} <= '0;
            {vs_out, hs_out, de_out, pixel_out} <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_cnt <= clr_cnt + 5'd1;
            init_done <= state == RUN;
            // Phase only moves on a vsync rising edge, so a frame never tears.
            vs_q <= vs_in;
            if (vs_in && !vs_q) begin
                frame_cnt <= frame_cnt == FB'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
                if (frame_cnt == FB'(BLINK_FRAMES - 1)) blink_phase <= ~blink_phase;
            end
            s1_hit <= hit;
            s1_ov <= overlay_en && state == RUN && !(blink_en && blink_phase);
            s1_col <= dx[7:3];
            s1_bit <= dx[2:0];
            s1_row <= dy;
            s1_sync <= {vs_in, hs_in, de_in};
            s1_pix <= pixel_in;
            code <= mem[s1_col];
            {s2_hit, s2_ov, s2_bit, s2_row, s2_sync, s2_pix} <= {s1_hit, s1_ov, s1_bit, s1_row, s1_sync, s1_pix};
            if (s2_hit) font_addr <= {code, s2_row};
            {s3_hit, s3_ov, s3_bit, s3_sync, s3_pix} <= {s2_hit, s2_ov, s2_bit, s2_sync, s2_pix};
            {s4_hit, s4_ov, s4_bit, s4_sync, s4_pix} <= {s3_hit, s3_ov, s3_bit, s3_sync, s3_pix};
            {vs_out, hs_out, de_out} <= s4_sync;
            pixel_out <= pix_sel;
        end
    end
endmodule

// File: tb/tb_hdmi_char_overlay.sv
// tb_hdmi_char_overlay: directed checks of the text overlay with a small font ROM model.
module tb_hdmi_char_overlay;
    logic        pix_clk = 0, rst = 1;
    logic        vs_in = 0, hs_in = 0, de_in = 0;
    logic [11:0] x_in = 0, y_in = 0;
    logic [23:0] pixel_in = 0;
    logic        char_we = 0;
    logic [4:0]  char_waddr = 0;
    logic [7:0]  char_wdata = 0;
    logic        overlay_en = 0, blink_en = 0;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic        vs_out, hs_out, de_out, init_done;
    logic [23:0] pixel_out;
    int total = 0, bad = 0;

    hdmi_char_overlay #(.BLINK_FRAMES(2)) dut (
        .pix_clk(pix_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .x_in(x_in), .y_in(y_in), .pixel_in(pixel_in), .char_we(char_we),
        .char_waddr(char_waddr), .char_wdata(char_wdata), .overlay_en(overlay_en),
        .blink_en(blink_en), .font_addr(font_addr), .font_row(font_row),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .pixel_out(pixel_out),
        .init_done(init_done)
    );

    always #5 pix_clk = ~pix_clk;

    // 0x41: only row 0 leftmost pixel; 0x23: solid; 0x42: solid except row 15 = rightmost pixel only.
    function automatic logic [7:0] rom(input logic [10:0] a);
        if (a[10:4] == 7'h41) return a[3:0] == 4'd0 ? 8'h80 : 8'h00;
        if (a[10:4] == 7'h23) return 8'hFF;
        if (a[10:4] == 7'h42) return a[3:0] == 4'd15 ? 8'h01 : 8'hFF;
        return 8'h00;
    endfunction

    always_ff @(posedge pix_clk) font_row <= rom(font_addr);

    task automatic step();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] x, input logic [11:0] y, input logic d, input logic [23:0] p);
        x_in = x; y_in = y; de_in = d; pixel_in = p;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        char_we = 1; char_waddr = a; char_wdata = d;
        step();
        char_we = 0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1;
        repeat (3) step();
        total++;
        if ({vs_out, hs_out, de_out, init_done, pixel_out, font_addr} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {vs_out, hs_out, de_out, init_done, pixel_out, font_addr});
        end
        rst = 0;
        char_we = 1; char_waddr = 0; char_wdata = 8'h41;
        step();
        char_we = 0;
        n = 1;
        while (init_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n != 33) begin
            bad++;
            $display("FAIL init_latency: got %0d want 33", n);
        end
        overlay_en = 1;
        for (int k = 0; k < 32; k += 31) begin
            drive(12'(64 + 8 * k), 12'd64, 1, 24'h0F1E2D);
            step();
            drive(0, 0, 0, 0);
            step(); step();
            total++;
            if (font_addr !== 11'h200) begin
                bad++;
                $display("FAIL cleared_addr col%0d: got %h want 200", k, font_addr);
            end
            step(); step();
            total++;
            if (pixel_out !== 24'h0F1E2D) begin
                bad++;
                $display("FAIL cleared_pixel col%0d: got %h want 0f1e2d", k, pixel_out);
            end
        end
    endtask

    task automatic test_char_write();
        wr(0, 8'h41);
        drive(12'd64, 12'd64, 1, 24'h123456);
        step();
        drive(12'd65, 12'd64, 1, 24'h123456);
        step();
        drive(0, 0, 0, 0);
        step();
        total++;
        if (font_addr !== 11'h410) begin
            bad++;
            $display("FAIL char_font_addr: got %h want 410", font_addr);
        end
        step(); step();
        total++;
        if ({de_out, pixel_out} !== {1'b1, 24'hFFFFFF}) begin
            bad++;
            $display("FAIL char_fg: got %h want 1ffffff", {de_out, pixel_out});
        end
        step();
        total++;
        if (pixel_out !== 24'h123456) begin
            bad++;
            $display("FAIL char_bg_transparent: got %h want 123456", pixel_out);
        end
    endtask

    task automatic test_boundary();
        logic [11:0] xs [8] = '{12'd64, 12'd63, 12'd320, 12'd64, 12'd64, 12'd319, 12'd312, 12'd311};
        logic [11:0] ys [8] = '{12'd64, 12'd64, 12'd64, 12'd63, 12'd80, 12'd79, 12'd79, 12'd79};
        logic        fg [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [23:0] want;
        for (int a = 0; a < 32; a++) wr(5'(a), 8'h23);
        wr(31, 8'h42);
        for (int i = 0; i < 8; i++) begin
            drive(xs[i], ys[i], 1, 24'h445566);
            step();
            drive(0, 0, 0, 0);
            repeat (4) step();
            want = fg[i] ? 24'hFFFFFF : 24'h445566;
            total++;
            if (pixel_out !== want) begin
                bad++;
                $display("FAIL boundary x=%0d y=%0d: got %h want %h", xs[i], ys[i], pixel_out, want);
            end
        end
    endtask

    task automatic test_sync_passthrough();
        logic [26:0] v [24];
        overlay_en = 0;
        for (int i = 0; i < 24; i++)
            v[i] = {i % 7 == 3, i % 3 == 0, i % 2 == 1, 24'(32'h010203 * i) ^ 24'hA5A5A5};
        for (int j = 0; j < 28; j++) begin
            if (j < 24) begin
                {vs_in, hs_in, de_in, pixel_in} = v[j];
                x_in = 12'(64 + j); y_in = 12'd64;
            end else begin
                {vs_in, hs_in} = 2'b00;
                drive(0, 0, 0, 0);
            end
            step();
            if (j >= 4) begin
                total++;
                if ({vs_out, hs_out, de_out, pixel_out} !== v[j-4]) begin
                    bad++;
                    $display("FAIL sync_delay idx%0d: got %h want %h", j - 4, {vs_out, hs_out, de_out, pixel_out}, v[j-4]);
                end
            end
        end
    endtask

    task automatic test_blink();
        int n;
        logic [23:0] want;
        rst = 1;
        repeat (2) step();
        rst = 0;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL blink_init: got %b want 1", init_done);
        end
        wr(0, 8'h23);
        overlay_en = 1; blink_en = 1;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
                vs_in = 1; step();
                vs_in = 0; step();
            end
            want = (f == 2 || f == 3) ? 24'h00AA55 : 24'hFFFFFF;
            for (int r = 0; r < 2; r++) begin
                drive(12'd64, 12'd64, 1, 24'h00AA55);
                step();
                drive(0, 0, 0, 0);
                repeat (4) step();
                total++;
                if (pixel_out !== want) begin
                    bad++;
                    $display("FAIL blink frame%0d probe%0d: got %h want %h", f, r, pixel_out, want);
                end
            end
        end
        blink_en = 0;
    endtask

    task automatic test_mid_reset();
        int n;
        overlay_en = 1;
        vs_in = 1; hs_in = 1;
        drive(12'd64, 12'd64, 1, 24'h111111);
        step(); step();
        rst = 1;
        step();
        total++;
        if ({vs_out, hs_out, de_out, init_done, pixel_out, font_addr} !== 39'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h want 0", {vs_out, hs_out, de_out, init_done, pixel_out, font_addr});
        end
        rst = 0;
        vs_in = 0; hs_in = 0;
        drive(0, 0, 0, 0);
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n != 33) begin
            bad++;
            $display("FAIL midreset_init: got %0d want 33", n);
        end
        drive(12'd64, 12'd64, 1, 24'h222222);
        step();
        drive(0, 0, 0, 0);
        repeat (4) step();
        total++;
        if ({de_out, pixel_out} !== {1'b1, 24'h222222}) begin
            bad++;
            $display("FAIL midreset_pass: got %h want 1222222", {de_out, pixel_out});
        end
    endtask

    initial begin
        test_reset();
        test_char_write();
        test_boundary();
        test_sync_passthrough();
        test_blink();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
